// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - MEM-stage load/store unit with request/ready data bus, lane steering and load extension
module dmem_lsu #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memreadM,
    input  logic                 memwriteM,
    input  logic [1:0]           lwhbM,
    input  logic [1:0]           swhbM,
    input  logic                 lunsignedM,
    input  logic [XLEN-1:0]      aluoutM,
    input  logic [XLEN-1:0]      writedataM,
    output logic                 stallM,
    output logic                 misalignM,
    output logic [XLEN-1:0]      readdataM,
    output logic                 ldvalidM,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [ADDR_SIZE-1:0] bus_addr,
    output logic [XLEN-1:0]      bus_wdata,
    output logic [3:0]           bus_wstrb,
    input  logic                 bus_ready,
    input  logic [XLEN-1:0]      bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic           op, is_store, mis;
    logic [1:0]     acc_size;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]     st_wstrb;
    logic [1:0]     ld_size;
    logic           ld_uns;
    logic [1:0]     ld_off;
    logic           ld_en;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [XLEN-1:0] ld_ext;

    // Decode the MEM-stage request: a simultaneous read+write is a store
    always_comb begin
        op       = memreadM | memwriteM;
        is_store = memwriteM;
        acc_size = is_store ? swhbM : lwhbM;
        case (acc_size)
            2'b01:   mis = aluoutM[0];
            2'b10:   mis = 1'b0;
            default: mis = |aluoutM[1:0];
        endcase
        misalignM = op & mis;
    end

    // Store lane steering: replicate data across lanes, enable only the addressed bytes
    always_comb begin
        case (swhbM)
            2'b10: begin
                st_wdata = {4{writedataM[7:0]}};
                st_wstrb = 4'b0001 << aluoutM[1:0];
            end
            2'b01: begin
                st_wdata = {2{writedataM[15:0]}};
                st_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = writedataM;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the latched size/offset
    always_comb begin
        ld_byte = bus_rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (ld_size)
            2'b10:   ld_ext = ld_uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = ld_uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and pipeline stall; DONE never issues, so an instruction runs once
    always_comb begin
        state_nxt = state;
        stallM    = 1'b0;
        case (state)
            IDLE: begin
                if (op && !mis) begin
                    stallM    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stallM = 1'b1;
                if (bus_ready) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered bus outputs and load result; bus fields stay frozen while BUSY
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
            readdataM <= '0;
            ldvalidM  <= 1'b0;
            ld_size   <= 2'b00;
            ld_uns    <= 1'b0;
            ld_off    <= 2'b00;
            ld_en     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op && !mis) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= ADDR_SIZE'({aluoutM[XLEN-1:2], 2'b00});
                        bus_wdata <= is_store ? st_wdata : '0;
                        bus_wstrb <= is_store ? st_wstrb : 4'b0000;
                        ld_size   <= lwhbM;
                        ld_uns    <= lunsignedM;
                        ld_off    <= aluoutM[1:0];
                        ld_en     <= !is_store;
                    end
                end
                BUSY: begin
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (ld_en) begin
                            readdataM <= ld_ext;
                            ldvalidM  <= 1'b1;
                        end
                    end
                end
                DONE:    ldvalidM <= 1'b0;
                default: ldvalidM <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreadM, memwriteM, lunsignedM;
    logic [1:0]  lwhbM, swhbM;
    logic [31:0] aluoutM, writedataM;
    logic        stallM, misalignM, ldvalidM;
    logic [31:0] readdataM;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int vectors = 0;
    int miscompares = 0;

    dmem_lsu #(.XLEN(32), .ADDR_SIZE(32)) dut (
        .clk(clk), .reset(reset),
        .memreadM(memreadM), .memwriteM(memwriteM),
        .lwhbM(lwhbM), .swhbM(swhbM), .lunsignedM(lunsignedM),
        .aluoutM(aluoutM), .writedataM(writedataM),
        .stallM(stallM), .misalignM(misalignM),
        .readdataM(readdataM), .ldvalidM(ldvalidM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memreadM = 1'b0; memwriteM = 1'b0; lwhbM = 2'b00; swhbM = 2'b00;
        lunsignedM = 1'b0; aluoutM = 32'h0; writedataM = 32'h0;
    endtask

    // Issue one aligned access at a negedge, answer bus_ready after 'delay' wait cycles,
    // and check the bus fields each BUSY cycle plus the stall count and load result.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [1:0] lsz, input logic [1:0] ssz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int delay,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb, input int exp_stalls,
                             input logic [31:0] exp_rd);
        int stalls = 0;
        int busy = 0;
        bit done = 0;
        logic is_load = rd & ~wr;
        memreadM = rd; memwriteM = wr; lwhbM = lsz; swhbM = ssz; lunsignedM = uns;
        aluoutM = addr; writedataM = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (stallM) begin
                stalls++;
                if (bus_req) begin
                    chk({tag, " bus_addr"}, bus_addr, exp_addr);
                    chk({tag, " bus_wdata"}, bus_wdata, exp_wdata);
                    chk({tag, " bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, exp_wstrb});
                    chk({tag, " bus_we"}, {31'h0, bus_we}, {31'h0, wr});
                    if (busy == delay) begin
                        bus_ready = 1'b1;
                        bus_rdata = rdata;
                    end
                    busy++;
                end
                @(posedge clk);
                @(negedge clk);
                bus_ready = 1'b0;
                bus_rdata = 32'h0;
            end else begin
                done = 1;
            end
        end
        chk({tag, " completed"}, {31'h0, done}, 32'h1);
        chk({tag, " stall cycles"}, stalls, exp_stalls);
        chk({tag, " bus_req in DONE"}, {31'h0, bus_req}, 32'h0);
        chk({tag, " ldvalidM in DONE"}, {31'h0, ldvalidM}, {31'h0, is_load});
        if (is_load) chk({tag, " readdataM"}, readdataM, exp_rd);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({tag, " ldvalidM after"}, {31'h0, ldvalidM}, 32'h0);
        chk({tag, " stallM after"}, {31'h0, stallM}, 32'h0);
    endtask

    task automatic do_misalign(input string tag, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic [31:0] addr);
        memreadM = rd; memwriteM = wr; lwhbM = sz; swhbM = sz; aluoutM = addr;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk({tag, " misalignM"}, {31'h0, misalignM}, 32'h1);
            chk({tag, " stallM"}, {31'h0, stallM}, 32'h0);
            chk({tag, " bus_req"}, {31'h0, bus_req}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk({tag, " misalignM no op"}, {31'h0, misalignM}, 32'h0);
    endtask

    initial begin
        idle_inputs();
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset bus_req", {31'h0, bus_req}, 32'h0);
        chk("reset stallM", {31'h0, stallM}, 32'h0);
        chk("reset readdataM", readdataM, 32'h0);
        chk("reset ldvalidM", {31'h0, ldvalidM}, 32'h0);
        chk("reset bus_addr", bus_addr, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        do_access("LW", 1, 0, 2'b00, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                  32'h100, 32'h0, 4'b0000, 2, 32'hDEADBEEF);
        do_access("SB", 0, 1, 2'b00, 2'b10, 0, 32'h203, 32'h123456A5, 32'h0, 0,
                  32'h200, 32'hA5A5A5A5, 4'b1000, 2, 32'h0);
        do_access("LH", 1, 0, 2'b01, 2'b00, 0, 32'h302, 32'h0, 32'h80017FFF, 0,
                  32'h300, 32'h0, 4'b0000, 2, 32'hFFFF8001);
        do_access("LHU", 1, 0, 2'b01, 2'b00, 1, 32'h302, 32'h0, 32'h80017FFF, 0,
                  32'h300, 32'h0, 4'b0000, 2, 32'h00008001);
        do_access("LB", 1, 0, 2'b10, 2'b00, 0, 32'h301, 32'h0, 32'h00008000, 0,
                  32'h300, 32'h0, 4'b0000, 2, 32'hFFFFFF80);
        do_access("LBU", 1, 0, 2'b10, 2'b00, 1, 32'h303, 32'h0, 32'h9A000000, 1,
                  32'h300, 32'h0, 4'b0000, 3, 32'h0000009A);
        do_access("SW delayed", 0, 1, 2'b00, 2'b00, 0, 32'h40, 32'hCAFEF00D, 32'h0, 3,
                  32'h40, 32'hCAFEF00D, 4'b1111, 5, 32'h0);
        do_access("SH", 0, 1, 2'b00, 2'b01, 0, 32'h46, 32'h0000BEEF, 32'h0, 0,
                  32'h44, 32'hBEEFBEEF, 4'b1100, 2, 32'h0);
        do_access("RD+WR is store", 1, 1, 2'b10, 2'b00, 0, 32'h10, 32'h11223344, 32'hFFFFFFFF, 0,
                  32'h10, 32'h11223344, 4'b1111, 2, 32'h0);

        do_misalign("LW 0x102", 1, 0, 2'b00, 32'h102);
        do_misalign("LH 0x105", 1, 0, 2'b01, 32'h105);
        do_access("SB 0x105", 0, 1, 2'b00, 2'b10, 0, 32'h105, 32'h00000077, 32'h0, 0,
                  32'h104, 32'h77777777, 4'b0010, 2, 32'h0);

        // Abandon an in-flight load with an asynchronous reset
        memreadM = 1'b1; lwhbM = 2'b00; aluoutM = 32'h100;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre-reset bus_req", {31'h0, bus_req}, 32'h1);
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("async reset bus_req", {31'h0, bus_req}, 32'h0);
        chk("async reset bus_addr", bus_addr, 32'h0);
        chk("async reset bus_we", {31'h0, bus_we}, 32'h0);
        chk("async reset bus_wdata", bus_wdata, 32'h0);
        chk("async reset bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("async reset readdataM", readdataM, 32'h0);
        chk("async reset ldvalidM", {31'h0, ldvalidM}, 32'h0);
        chk("async reset stallM", {31'h0, stallM}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset stallM", {31'h0, stallM}, 32'h0);
        @(negedge clk);
        do_access("LW after reset", 1, 0, 2'b00, 2'b00, 0, 32'h80, 32'h0, 32'h13579BDF, 1,
                  32'h80, 32'h0, 4'b0000, 3, 32'h13579BDF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit in the MEM stage of the 5-stage pipeline, directly downstream of EX/MEM.
- Takes the registered ALU address, store data and memory control of the MEM-stage instruction.
- Runs one word-aligned request/ready transaction on the data-memory bus, with byte-lane steering and load extension.
- Stalls the pipeline until the access completes, then presents the extended load data for MEM/WB.

Parameters:
XLEN, 32, data width; fixed at 32 (4 byte lanes).
ADDR_SIZE, 32, bus address width.

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-low reset.
memreadM  input  1  MEM-stage instruction is a load.
memwriteM  input  1  MEM-stage instruction is a store.
lwhbM  input  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
swhbM  input  2  store size, same encoding.
lunsignedM  input  1  zero-extend load (LBU/LHU) when 1.
aluoutM  input  XLEN  effective byte address.
writedataM  input  XLEN  store data (rs2, low bits significant).
stallM  output  1  hold IF..MEM stages and bubble WB this cycle.
misalignM  output  1  access misaligned; no bus op issued.
readdataM  output  XLEN  extended load data, valid when ldvalidM=1.
ldvalidM  output  1  readdataM valid this cycle.
bus_req  output  1  transaction request.
bus_we  output  1  1 = write.
bus_addr  output  ADDR_SIZE  word address ({aluoutM[31:2],2'b00}).
bus_wdata  output  XLEN  lane-replicated store data.
bus_wstrb  output  4  byte enables; 0000 on reads.
bus_ready  input  1  slave completes the transaction this cycle.
bus_rdata  input  XLEN  read word, valid with bus_ready.

Behaviour:
- op = memreadM|memwriteM. If both are set, it is a store.
- Misalign rule:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - byte is never misaligned.
- FSM states: IDLE, BUSY, DONE. All bus outputs, readdataM and ldvalidM are registered.
- IDLE:
  - op and aligned: stallM=1; latch bus_addr/bus_we/bus_wdata/bus_wstrb and the load size/sign/offset; bus_req<=1; go to BUSY.
  - op and misaligned: misalignM=1 (combinational), stallM=0, no bus activity, stay IDLE.
  - no op: stallM=0.
- BUSY:
  - stallM=1 and bus_req=1.
  - All bus outputs are held stable until bus_ready is sampled high.
  - On bus_ready: bus_req<=0; for loads, readdataM<=extend(bus_rdata) and ldvalidM<=1; go to DONE.
- DONE:
  - stallM=0, so the pipeline advances on this edge.
  - ldvalidM=1 for loads; 0 for stores.
  - Next state IDLE; ldvalidM<=0. No new request can issue from DONE, so no instruction is issued twice.
- Latency: bus_ready in the first BUSY cycle gives a 2-cycle stall. Each wait cycle of bus_ready adds one stall cycle.
- Store steering:
  - byte: wdata={4{wd[7:0]}}, wstrb=0001<<addr[1:0].
  - half: wdata={2{wd[15:0]}}, wstrb=0011<<(2*addr[1]).
  - word: wdata=wd, wstrb=1111.
- Load extraction:
  - byte: lane addr[1:0]; half: lane addr[1]; then sign- or zero-extend per lunsigned.
  - word: passed through unchanged.
- Reset, asynchronous, any state:
  - state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0.
  - readdataM=0, ldvalidM=0.
  - stallM follows IDLE rules, so with no op it is 0.
  - An in-flight transaction is abandoned. The bus slave is required to drop it when bus_req falls.
- bus_ready outside BUSY is ignored.
- misalignM is 0 whenever no op is present.

Test Plan:
- LW addr 0x100, bus_ready on the first BUSY cycle, rdata 0xDEADBEEF -> bus_addr=0x100, wstrb=0000, stallM high 2 cycles, DONE readdataM=0xDEADBEEF, ldvalidM=1.
- SB addr 0x203, writedataM=0x123456A5 -> bus_addr=0x200, wdata=0xA5A5A5A5, wstrb=1000, bus_we=1, ldvalidM stays 0.
- LH addr 0x302, rdata 0x8001_7FFF -> readdataM=0xFFFF8001. Same access as LHU -> readdataM=0x00008001. LB addr 0x301, rdata 0x0000_8000 -> 0xFFFFFF80.
- bus_ready delayed 3 cycles on SW addr 0x40, data 0xCAFEF00D -> stallM high 5 cycles; bus_addr/wdata/wstrb/we stable throughout; wstrb=1111.
- LW addr 0x102 and LH addr 0x105 -> misalignM=1, stallM=0, bus_req never asserted. SB addr 0x105 -> no misalign.
- reset low during BUSY with bus_ready held 0 -> bus_req=0 and all registered outputs 0 immediately. After reset releases with no op: IDLE, stallM=0. A fresh LW then completes normally.
